keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000; clock cycles each column stays driven (one column slot); legal range >= 4.
REQ-002 Parameter DEBOUNCE_FRAMES, default 4; consecutive identical frames required to accept a press or a release; legal range 2..15.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 key_row  input  4  matrix rows; active-low (pulled up); asynchronous to clk.
REQ-006 key_col  output  4  matrix column drive; active-low, exactly one bit low at all times.
REQ-007 key_valid  output  1  single-cycle strobe marking one accepted key press.
REQ-008 key_value  output  4  code of the last accepted key; valid while key_valid=1 and held afterwards.
REQ-009 key_held  output  1  high while the accepted key is still considered pressed.

Function
REQ-010 key_row SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Column counter col_idx (0..3) SHALL advance every SCAN_DIV cycles, wrapping 3->0; key_col = ~(1<<col_idx).
REQ-012 Synchronized rows SHALL be sampled on the last cycle of each column slot only.
REQ-013 A frame is the 4 slots from col 0 to col 3; frame ends on the last cycle of the col-3 slot.
REQ-014 Key code for row r, col c: r0 = 1,2,3,12; r1 = 4,5,6,13; r2 = 7,8,9,14; r3 = 10(*),0,11(#),15.
REQ-015 Frame result SHALL be one of: NONE (no low row bit in any slot), SINGLE(code) (exactly one low bit in the whole frame), MULTI (two or more).
REQ-016 Stability counter: at frame end, a result equal to the previous frame's result increments the counter, saturating at DEBOUNCE_FRAMES; a different result sets it to 1.
REQ-017 FSM states IDLE and PRESSED.
REQ-018 IDLE -> PRESSED when the counter reaches DEBOUNCE_FRAMES with result SINGLE(code); key_value <= code; key_valid = 1 for exactly the next cycle.
REQ-019 PRESSED -> IDLE when the counter reaches DEBOUNCE_FRAMES with result NONE; no strobe on release.
REQ-020 In PRESSED, SINGLE of a different code or MULTI SHALL NOT strobe or change key_value; a fresh key requires a stable release first.
REQ-021 In IDLE, stable MULTI SHALL produce no strobe and no state change.
REQ-022 At most one key_valid per press; no auto-repeat regardless of hold duration.
REQ-023 Latency: key_valid rises the cycle after the frame end where the counter reaches DEBOUNCE_FRAMES.
REQ-024 key_held = 1 exactly when the state is PRESSED.
REQ-025 The scan never stalls; key_col cycles continuously regardless of state.

Reset
REQ-026 While rst=1: col_idx=0, key_col=4'b1110, key_valid=0, key_value=0, key_held=0, state IDLE, stability counter 0, previous result NONE, synchronizer flops all 1.
REQ-027 Reset asserted mid-frame or mid-press SHALL discard the partial frame and debounce history; a key still held after reset is accepted as a new press after DEBOUNCE_FRAMES stable frames.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=16 cycles)
REQ-028 Hold row1 low while col1 is driven (key 5) for 10 frames -> exactly one key_valid pulse, key_value=5, key_held=1 until release.
REQ-029 Press key at r3,c0 then, after release, key at r3,c2 -> two pulses, key_value=10 then 11.
REQ-030 Toggle r0,c0 on every other frame for 8 frames -> no key_valid; counter never reaches 3.
REQ-031 Hold keys 1 and 2 together for 6 frames -> no pulse, key_held=0; then release key 2 and hold key 1 for 3 frames -> one pulse, key_value=1.
REQ-032 While holding key 9 (PRESSED), add key 8 for 5 frames, then release key 8 only -> no further pulse, key_value stays 9.
REQ-033 Assert rst for 1 cycle mid-press of key 0 -> outputs return to reset values next cycle; key_col=1110; key still held -> new pulse with key_value=0 after 3 stable frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time,
// classifies each 4-column frame as NONE / SINGLE(code) / MULTI,
// debounces on consecutive identical frames and emits a one-cycle strobe
// for every accepted press.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no key accepted; waiting for a stable SINGLE frame
// ST_PRESSED | key accepted and strobed; waiting for a stable NONE frame
module keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic [3:0] key_value,
    output logic       key_held
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       STAB_MAX = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_kind_t;
    typedef enum logic {ST_IDLE, ST_PRESSED} state_t;

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic             slot_end;
    logic             frame_end;

    logic [3:0]       row_low;
    logic [2:0]       slot_hits;
    logic [1:0]       slot_row;

    res_kind_t        acc_kind;
    logic [3:0]       acc_code;
    res_kind_t        frame_kind;
    logic [3:0]       frame_code;

    res_kind_t        prev_kind;
    logic [3:0]       prev_code;
    logic [3:0]       stab_cnt;
    logic [3:0]       stab_next;
    logic             stable_hit;

    state_t           state;
    state_t           state_next;
    logic             press_accept;

    // Row code table: rows 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'd0;
        case ({row, col})
            4'd0:  code = 4'd1;
            4'd1:  code = 4'd2;
            4'd2:  code = 4'd3;
            4'd3:  code = 4'd12;
            4'd4:  code = 4'd4;
            4'd5:  code = 4'd5;
            4'd6:  code = 4'd6;
            4'd7:  code = 4'd13;
            4'd8:  code = 4'd7;
            4'd9:  code = 4'd8;
            4'd10: code = 4'd9;
            4'd11: code = 4'd14;
            4'd12: code = 4'd10;
            4'd13: code = 4'd0;
            4'd14: code = 4'd11;
            default: code = 4'd15;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer on the asynchronous, pulled-up rows
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
        end
    end

    // Slot timer (down-counter, terminal count at zero) and column index
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= DIV_LOAD;
            col_idx <= 2'd0;
        end else if (slot_end) begin
            div_cnt <= DIV_LOAD;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt - DIV_W'(1);
        end
    end

    assign slot_end  = (div_cnt == '0);
    assign frame_end = slot_end && (col_idx == 2'd3);
    assign key_col   = ~(4'b0001 << col_idx);

    // Merge the current slot's row sample into the running frame result
    always_comb begin
        row_low    = ~row_sync;
        slot_hits  = {2'b00, row_low[0]} + {2'b00, row_low[1]}
                   + {2'b00, row_low[2]} + {2'b00, row_low[3]};
        slot_row   = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_low[r]) slot_row = 2'(r);
        end
        frame_kind = acc_kind;
        frame_code = acc_code;
        if (slot_hits > 3'd1) begin
            frame_kind = RES_MULTI;
        end else if (slot_hits == 3'd1) begin
            if (acc_kind == RES_NONE) begin
                frame_kind = RES_SINGLE;
                frame_code = key_code(slot_row, col_idx);
            end else begin
                frame_kind = RES_MULTI;
            end
        end
    end

    // Frame accumulator; cleared at frame end so each frame starts fresh
    always_ff @(posedge clk) begin
        if (rst || frame_end) begin
            acc_kind <= RES_NONE;
            acc_code <= 4'd0;
        end else if (slot_end) begin
            acc_kind <= frame_kind;
            acc_code <= frame_code;
        end
    end

    // Stability count for the frame result that is completing now
    always_comb begin
        stab_next = 4'd1;
        if ((frame_kind == prev_kind) &&
            ((frame_kind != RES_SINGLE) || (frame_code == prev_code))) begin
            stab_next = (stab_cnt >= STAB_MAX) ? STAB_MAX : stab_cnt + 4'd1;
        end
        stable_hit = frame_end && (stab_next == STAB_MAX);
    end

    // Debounce history: previous frame result and its run length
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_kind <= RES_NONE;
            prev_code <= 4'd0;
            stab_cnt  <= 4'd0;
        end else if (frame_end) begin
            prev_kind <= frame_kind;
            prev_code <= frame_code;
            stab_cnt  <= stab_next;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; MULTI or a different SINGLE never moves PRESSED
    always_comb begin
        state_next   = state;
        press_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                if (stable_hit && (frame_kind == RES_SINGLE)) begin
                    state_next   = ST_PRESSED;
                    press_accept = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (stable_hit && (frame_kind == RES_NONE)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        key_held = (state == ST_PRESSED);
    end

    // Press strobe and held key code, registered one cycle after frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_value <= 4'd0;
        end else begin
            key_valid <= press_accept;
            if (press_accept) key_value <= frame_code;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives the rows,
// a frame-level reference model predicts accepted presses, and a monitor
// checks every strobe, the column scan and the held state.
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DF    = 3;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic        key_valid;
    logic [3:0]  key_value;
    logic        key_held;
    logic [15:0] pressed = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;
    bit armed = 1'b0;

    // Key codes indexed by row*4 + col
    int code_tab [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};

    typedef struct {
        int code;
        int frame;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state (frame granularity)
    int m_prev_kind;   // 0 none, 1 single, 2 multi
    int m_prev_code;
    int m_stab;
    int m_fnum;
    int m_last_code;
    bit m_held;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_valid (key_valid),
        .key_value (key_value),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its row to its column when driven low
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: column scan every cycle, strobes against the scoreboard
    always @(negedge clk) begin
        if (armed && !rst) begin
            logic [3:0] exp_col;
            exp_col = ~(4'b0001 << ((edges / SD) % 4));
            check("key_col", int'(key_col), int'(exp_col));
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected key_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("strobe key_value", int'(key_value), e.code);
                    check("strobe cycle", edges, e.frame * FRAME);
                end
            end
        end
    end

    function automatic logic [15:0] kb(input int code);
        for (int i = 0; i < 16; i++)
            if (code_tab[i] == code) return 16'(1) << i;
        return '0;
    endfunction

    task automatic model_reset();
        m_prev_kind = 0;
        m_prev_code = 0;
        m_stab      = 0;
        m_fnum      = 0;
        m_last_code = 0;
        m_held      = 1'b0;
    endtask

    // One frame of the rules: classify by number of pressed keys, debounce, accept
    task automatic model_frame(input logic [15:0] mask);
        int n, kind, code;
        exp_t e;
        n    = $countones(mask);
        kind = (n == 0) ? 0 : (n == 1) ? 1 : 2;
        code = 0;
        for (int i = 0; i < 16; i++) if (mask[i] && n == 1) code = code_tab[i];
        m_fnum++;
        if (kind == m_prev_kind && (kind != 1 || code == m_prev_code))
            m_stab = (m_stab + 1 > DF) ? DF : m_stab + 1;
        else
            m_stab = 1;
        m_prev_kind = kind;
        m_prev_code = code;
        if (m_stab == DF) begin
            if (!m_held && kind == 1) begin
                m_held      = 1'b1;
                m_last_code = code;
                e.code  = code;
                e.frame = m_fnum;
                exp_q.push_back(e);
            end else if (m_held && kind == 0) begin
                m_held = 1'b0;
            end
        end
    endtask

    // Called on a negedge; leaves on the negedge after the frame-end edge
    task automatic run_frame(input logic [15:0] mask);
        pressed = mask;
        repeat (FRAME) @(posedge clk);
        model_frame(mask);
        @(negedge clk);
        check("key_held", int'(key_held), int'(m_held));
        check("key_value held", int'(key_value), m_last_code);
    endtask

    task automatic run_frames(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) run_frame(mask);
    endtask

    // Reset for a number of cycles, leaving the bench on a negedge
    task automatic do_reset(input int cycles);
        if (armed) check("pending strobes at reset", exp_q.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("reset key_col", int'(key_col), 4'b1110);
        check("reset key_valid", int'(key_valid), 0);
        check("reset key_value", int'(key_value), 0);
        check("reset key_held", int'(key_held), 0);
        exp_q.delete();
        model_reset();
        rst   = 1'b0;
        armed = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset(3);

        // Long hold of key 5, then release
        run_frames(kb(5), 10);
        run_frames('0, 4);

        // Key * then key #
        run_frames(kb(10), 5);
        run_frames('0, 4);
        run_frames(kb(11), 5);
        run_frames('0, 4);

        // Bouncing key 1: never stable long enough
        for (int i = 0; i < 4; i++) begin
            run_frame(kb(1));
            run_frame('0);
        end
        run_frames('0, 3);

        // Two keys together, then one released
        run_frames(kb(1) | kb(2), 6);
        run_frames(kb(1), 3);
        run_frames('0, 4);

        // Second key added while first is accepted, then removed
        run_frames(kb(9), 4);
        run_frames(kb(9) | kb(8), 5);
        run_frames(kb(9), 4);
        run_frames('0, 4);

        // Reset mid-press of key 0; the still-held key is accepted afresh
        run_frames(kb(0), 4);
        pressed = kb(0);
        repeat (7) @(posedge clk);
        do_reset(1);
        run_frames(kb(0), 4);
        run_frames('0, 4);

        // Randomised runs of 0, 1 or 2 keys with random hold lengths
        for (int k = 0; k < 70; k++) begin
            int sel, a, b, len;
            logic [15:0] mask;
            sel  = $urandom_range(0, 9);
            a    = $urandom_range(0, 15);
            b    = (a + 1 + $urandom_range(0, 14)) % 16;
            len  = $urandom_range(1, 5);
            mask = '0;
            if (sel >= 3) mask[a] = 1'b1;
            if (sel == 9) mask[b] = 1'b1;
            run_frames(mask, len);
            if (k == 40) begin
                repeat ($urandom_range(1, 14)) @(posedge clk);
                do_reset(1);
            end
        end
        run_frames('0, 4);

        check("missing strobes", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
